// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-ID AXI4 slave backed by a synchronous word RAM.
// One burst in flight; INCR/FIXED bursts of 32-bit beats.
module axi_ram_slave #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  state_t state;

  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_ADDR_W-1:0] addr_next;
  logic [MEM_ADDR_W-1:0] raddr;
  logic [7:0]            len;
  logic [7:0]            cnt;
  logic                  fixed;
  logic                  err;
  logic                  werr;
  logic                  rprime;
  logic                  last;
  logic                  aw_hs;
  logic                  ar_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  aw_err;
  logic                  ar_err;
  logic                  we;
  logic                  wlast_bad;
  logic [DATA_W-1:0]     rd_q;
  logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];

  logic unused;
  assign unused = ^{axi_awid, axi_awlock, axi_awcache, axi_awprot,
                    axi_awqos, axi_awaddr, axi_arid, axi_arlock,
                    axi_arcache, axi_arprot, axi_arqos, axi_araddr};

  // Write wins a simultaneous request: AR is only offered without AW.
  assign axi_arready = axi_awready & ~axi_awvalid;

  assign aw_hs     = axi_awvalid & axi_awready;
  assign ar_hs     = axi_arvalid & axi_arready;
  assign w_hs      = axi_wvalid & axi_wready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign aw_err    = (axi_awsize != 3'b010) | axi_awburst[1];
  assign ar_err    = (axi_arsize != 3'b010) | axi_arburst[1];
  assign last      = (cnt == len);
  assign wlast_bad = (axi_wlast != last);
  assign addr_next = fixed ? addr : addr + 1'b1;
  assign we        = (state == WDATA) & w_hs & ~err;
  assign axi_rdata = rd_q;

  // RAM read address runs one beat ahead on each R handshake.
  always_comb begin
    raddr = addr;
    if (state == RDATA && r_hs) raddr = addr_next;
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      fixed       <= 1'b0;
      err         <= 1'b0;
      werr        <= 1'b0;
      rprime      <= 1'b0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          axi_awready <= 1'b1;
          if (aw_hs) begin
            addr        <= axi_awaddr[MEM_ADDR_W+1:2];
            len         <= axi_awlen;
            cnt         <= '0;
            err         <= aw_err;
            fixed       <= (axi_awburst == 2'b00) & ~aw_err;
            werr        <= 1'b0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            state       <= WDATA;
          end else if (ar_hs) begin
            addr        <= axi_araddr[MEM_ADDR_W+1:2];
            len         <= axi_arlen;
            cnt         <= '0;
            err         <= ar_err;
            fixed       <= (axi_arburst == 2'b00) & ~ar_err;
            rprime      <= 1'b0;
            axi_awready <= 1'b0;
            state       <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            cnt  <= cnt + 8'd1;
            addr <= addr_next;
            if (wlast_bad) werr <= 1'b1;
            if (last) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= (err | werr | wlast_bad) ? 2'b10 : 2'b00;
              state      <= WRESP;
            end
          end
        end
        WRESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_bresp   <= 2'b00;
            axi_awready <= 1'b1;
            state       <= IDLE;
          end
        end
        RDATA: begin
          if (!axi_rvalid) begin
            if (rprime) begin
              axi_rvalid <= 1'b1;
              axi_rlast  <= last;
              axi_rresp  <= err ? 2'b10 : 2'b00;
            end else begin
              rprime <= 1'b1;
            end
          end else if (axi_rready) begin
            cnt       <= cnt + 8'd1;
            addr      <= addr_next;
            axi_rlast <= (cnt + 8'd1 == len);
            if (last) begin
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              axi_rresp   <= 2'b00;
              axi_awready <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_wstrb[b]) mem[addr][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // Synchronous RAM read; output register clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= mem[raddr];
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed and randomized bursts checked
// against an associative-array memory model.
module tb_axi_ram_slave;

  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axi_awid, axi_awlock, axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize, axi_awprot;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awcache, axi_awqos;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic        axi_arid, axi_arlock, axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize, axi_arprot;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arcache, axi_arqos;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;
  logic [41:0] outs;

  assign outs = {axi_awready, axi_wready, axi_bvalid, axi_bresp,
                 axi_arready, axi_rvalid, axi_rlast, axi_rresp,
                 axi_rdata};

  axi_ram_slave #(
    .ADDR_W(32),
    .DATA_W(32),
    .MEM_ADDR_W(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot),
    .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid),
    .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot),
    .axi_arqos(axi_arqos),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [2:0] sz,
                                  input logic [1:0] bt);
    return (sz != 3'd2) || bt[1];
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[MW+1:2]);
  endfunction

  function automatic logic [31:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxxxxxx;
  endfunction

  task automatic aw_hs(input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt);
    int g;
    g = 0;
    axi_awaddr = a; axi_awlen = len;
    axi_awsize = sz; axi_awburst = bt;
    axi_awvalid = 1'b1;
    #1;
    while (!axi_awready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check("awready", 64'(axi_awready), 64'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt);
    int g;
    g = 0;
    axi_araddr = a; axi_arlen = len;
    axi_arsize = sz; axi_arburst = bt;
    axi_arvalid = 1'b1;
    #1;
    while (!axi_arready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check("arready", 64'(axi_arready), 64'd1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
  endtask

  task automatic write_data(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt,
                            input int bad, input int bhold,
                            input string tag);
    int idx;
    logic e;
    logic [31:0] v;
    e = is_err(sz, bt);
    idx = widx(a);
    for (int i = 0; i <= int'(len); i++) begin
      axi_wdata = wd[i];
      axi_wstrb = ws[i];
      axi_wlast = (i == int'(len)) ^ (i == bad);
      axi_wvalid = 1'b1;
      check({tag, "_wready"}, 64'(axi_wready), 64'd1);
      @(posedge clk); #1;
      if (!e) begin
        v = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) v[8*b +: 8] = wd[i][8*b +: 8];
        ref_mem[idx] = v;
      end
      if (e || bt != 2'b00) idx = (idx + 1) % (1 << MW);
    end
    axi_wvalid = 1'b0;
    axi_wlast = 1'b0;
    check({tag, "_wdone"}, 64'(axi_wready), 64'd0);
    check({tag, "_bvalid"}, 64'(axi_bvalid), 64'd1);
    for (int h = 0; h < bhold; h++) begin
      check({tag, "_bhold"}, 64'({axi_bvalid, axi_awready, axi_arready}),
            64'(3'b100));
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    check({tag, "_bresp"}, 64'(axi_bresp),
          (e || bad >= 0) ? 64'd2 : 64'd0);
    @(posedge clk); #1;
    axi_bready = 1'b0;
    check({tag, "_bclr"}, 64'({axi_bvalid, axi_awready}), 64'(2'b01));
  endtask

  task automatic read_data(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt,
                           input logic stall, input string tag);
    int idx, lat;
    logic e;
    logic [35:0] held;
    e = is_err(sz, bt);
    idx = widx(a);
    lat = 0;
    while (!axi_rvalid && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd2);
    for (int i = 0; i <= int'(len); i++) begin
      if (stall && (i % 2 == 1)) begin
        axi_rready = 1'b0;
        held = {axi_rvalid, axi_rlast, axi_rresp, axi_rdata};
        @(posedge clk); #1;
        check({tag, "_hold"},
              64'({axi_rvalid, axi_rlast, axi_rresp, axi_rdata}),
              64'(held));
      end
      axi_rready = 1'b1;
      check({tag, "_rvalid"}, 64'(axi_rvalid), 64'd1);
      check({tag, "_rdata"}, 64'(axi_rdata), 64'(ref_rd(idx)));
      check({tag, "_rlast"}, 64'(axi_rlast), 64'(i == int'(len)));
      check({tag, "_rresp"}, 64'(axi_rresp), e ? 64'd2 : 64'd0);
      last_rdata = axi_rdata;
      @(posedge clk); #1;
      if (e || bt != 2'b00) idx = (idx + 1) % (1 << MW);
    end
    axi_rready = 1'b0;
    check({tag, "_rend"}, 64'(axi_rvalid), 64'd0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
  endtask

  initial begin
    int g;
    logic [31:0] a;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [1:0]  bt;
    int bad;
    axi_awid = 0; axi_awlock = 0; axi_awcache = 0; axi_awprot = 0;
    axi_awqos = 0; axi_awvalid = 0; axi_awaddr = 0; axi_awlen = 0;
    axi_awsize = 0; axi_awburst = 0;
    axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_wvalid = 0;
    axi_bready = 0;
    axi_arid = 0; axi_arlock = 0; axi_arcache = 0; axi_arprot = 0;
    axi_arqos = 0; axi_arvalid = 0; axi_araddr = 0; axi_arlen = 0;
    axi_arsize = 0; axi_arburst = 0; axi_rready = 0;

    #12;
    check("rst_outs", 64'(outs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rdy_pre", 64'(axi_awready), 64'd0);
    @(posedge clk); #1;
    check("rdy_post", 64'({axi_awready, axi_arready}), 64'(2'b11));

    fill(256);
    aw_hs(32'h0, 8'd255, 3'd2, 2'b01);
    write_data(32'h0, 8'd255, 3'd2, 2'b01, -1, 0, "init");

    fill(4);
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    aw_hs(32'h100, 8'd3, 3'd2, 2'b01);
    write_data(32'h100, 8'd3, 3'd2, 2'b01, -1, 0, "incr_w");
    ar_hs(32'h100, 8'd3, 3'd2, 2'b01);
    read_data(32'h100, 8'd3, 3'd2, 2'b01, 1'b0, "incr_r");
    check("incr_last", 64'(last_rdata), 64'h0A3);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    aw_hs(32'h200, 8'd0, 3'd2, 2'b01);
    write_data(32'h200, 8'd0, 3'd2, 2'b01, -1, 0, "strb_a");
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    aw_hs(32'h200, 8'd0, 3'd2, 2'b01);
    write_data(32'h200, 8'd0, 3'd2, 2'b01, -1, 0, "strb_b");
    ar_hs(32'h200, 8'd0, 3'd2, 2'b01);
    read_data(32'h200, 8'd0, 3'd2, 2'b01, 1'b0, "strb_r");
    check("strb_val", 64'(last_rdata), 64'h11BB33DD);

    ar_hs(32'h0, 8'd7, 3'd2, 2'b01);
    read_data(32'h0, 8'd7, 3'd2, 2'b01, 1'b1, "stall_r");
    fill(2);
    aw_hs(32'h40, 8'd1, 3'd2, 2'b01);
    write_data(32'h40, 8'd1, 3'd2, 2'b01, -1, 5, "bhold");

    fill(1);
    axi_araddr = 32'h300; axi_arlen = 0;
    axi_arsize = 3'd2; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    axi_awaddr = 32'h300; axi_awlen = 0;
    axi_awsize = 3'd2; axi_awburst = 2'b01; axi_awvalid = 1'b1;
    #1;
    check("sim_rdy", 64'({axi_awready, axi_arready}), 64'(2'b10));
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    write_data(32'h300, 8'd0, 3'd2, 2'b01, -1, 2, "sim_w");
    check("sim_ar", 64'(axi_arready), 64'd1);
    ar_hs(32'h300, 8'd0, 3'd2, 2'b01);
    read_data(32'h300, 8'd0, 3'd2, 2'b01, 1'b0, "sim_r");
    check("sim_val", 64'(last_rdata), 64'(wd[0]));

    fill(3);
    aw_hs(32'h304, 8'd2, 3'd2, 2'b00);
    write_data(32'h304, 8'd2, 3'd2, 2'b00, -1, 0, "fix_w");
    ar_hs(32'h304, 8'd0, 3'd2, 2'b01);
    read_data(32'h304, 8'd0, 3'd2, 2'b01, 1'b0, "fix_r");
    check("fix_val", 64'(last_rdata), 64'(wd[2]));

    fill(1);
    aw_hs(32'h100, 8'd0, 3'd1, 2'b01);
    write_data(32'h100, 8'd0, 3'd1, 2'b01, -1, 0, "sz_w");
    ar_hs(32'h100, 8'd0, 3'd2, 2'b01);
    read_data(32'h100, 8'd0, 3'd2, 2'b01, 1'b0, "sz_r");
    check("sz_keep", 64'(last_rdata), 64'h0A0);

    fill(4);
    aw_hs(32'h400, 8'd3, 3'd2, 2'b01);
    write_data(32'h400, 8'd3, 3'd2, 2'b01, 1, 0, "wlast_w");
    ar_hs(32'h400, 8'd3, 3'd2, 2'b01);
    read_data(32'h400, 8'd3, 3'd2, 2'b01, 1'b0, "wlast_r");

    ar_hs(32'h100, 8'd1, 3'd2, 2'b10);
    read_data(32'h100, 8'd1, 3'd2, 2'b10, 1'b0, "wrap_r");

    fill(1);
    aw_hs(32'h0004_0000, 8'd0, 3'd2, 2'b01);
    write_data(32'h0004_0000, 8'd0, 3'd2, 2'b01, -1, 0, "alias_w");
    ar_hs(32'h0, 8'd0, 3'd2, 2'b01);
    read_data(32'h0, 8'd0, 3'd2, 2'b01, 1'b0, "alias_r");
    check("alias_val", 64'(last_rdata), 64'(wd[0]));

    for (int t = 0; t < 8; t++) begin
      a = 32'($urandom_range(0, 200)) << 2;
      ln = 8'($urandom_range(0, 15));
      bt = 2'($urandom_range(0, 1));
      sz = ($urandom_range(0, 4) == 0) ? 3'd1 : 3'd2;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln)) : -1;
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
      aw_hs(a, ln, sz, bt);
      write_data(a, ln, sz, bt, bad, int'($urandom_range(0, 2)), "rnd_w");
      ar_hs(a, ln, 3'd2, bt);
      read_data(a, ln, 3'd2, bt, 1'($urandom), "rnd_r");
    end

    ar_hs(32'h0, 8'd7, 3'd2, 2'b01);
    g = 0;
    while (!axi_rvalid && g < 8) begin
      @(posedge clk); #1; g++;
    end
    axi_rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst", 64'(outs), 64'd0);
    axi_rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rel_pre", 64'(axi_awready), 64'd0);
    @(posedge clk); #1;
    check("rel_post", 64'({axi_awready, axi_arready}), 64'(2'b11));
    ar_hs(32'h0, 8'd7, 3'd2, 2'b01);
    read_data(32'h0, 8'd7, 3'd2, 2'b01, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
